array_divider_rv: RTL and testbench
===================================

# array_divider_rv

Parametrised pipelined integer divider with a ready/valid handshake on both sides, output backpressure, an optional signed mode, and divide-by-zero reporting. It succeeds the fixed-throughput array divider. Each datapath row retires one quotient bit by restoring division. Pipeline registers sit at a configurable number of row boundaries. It sits between an upstream producer and a consumer that may stall.

## Interface
- DATAWIDTH, 16: dividend, divisor, quotient and remainder width; legal range 4..64.
- NUM_PIPELINE_STAGES, 4: number of register boundaries; legal range 1..DATAWIDTH+1; equals the latency in cycles.
- INSTANCE_ID, 0: identification only; no functional effect.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_valid  in  1  operand pair presented.
- i_ready  out  1  block can accept the operand pair this cycle.
- A  in  DATAWIDTH  dividend.
- B  in  DATAWIDTH  divisor.
- i_signed  in  1  treat A/B as two's complement; present only with DIVIDER_SIGNED_EN.
- o_valid  out  1  result presented.
- o_ready  in  1  consumer accepts the result.
- Q_out  out  DATAWIDTH  quotient.
- R_out  out  DATAWIDTH  remainder.
- o_dbz  out  1  result came from B == 0.
- o_count  out  $clog2(DATAWIDTH+2)  number of operations in flight (accepted but not yet delivered).

## Operation
- Datapath rows:
  - DATAWIDTH rows; row i brings in dividend bit DATAWIDTH-1-i.
  - Each row does a compare and a conditional subtract on a DATAWIDTH-bit partial remainder, then appends the compare result to the quotient.
- Register boundaries:
  - Boundaries are numbered 0 (before row 0) through DATAWIDTH (after the last row).
  - Boundary DATAWIDTH is always registered and drives Q_out, R_out and o_dbz.
  - Boundaries 0..NUM_PIPELINE_STAGES-2 are also registered; all other boundaries are combinational.
- Each register slot carries: valid, partial remainder, partial quotient, dividend, divisor, dbz bit, and sign-fixup bits.
- Stall rule:
  - stall = o_valid & ~o_ready.
  - Every slot holds while stall is high and advances otherwise (global enable).
  - i_ready = ~stall; this is a combinational path from o_ready.
- Transfers:
  - Input transfer occurs when i_valid & i_ready.
  - An advancing slot whose predecessor is empty loads valid = 0, so bubbles propagate.
  - Output transfer occurs when o_valid & o_ready.
- Unsigned arithmetic: Q = floor(A/B) and R = A - Q*B.
- Divide by zero (B == 0), in either mode:
  - Q_out = all ones, R_out = A, o_dbz = 1.
  - This is the natural restoring-division result; signed fixup is suppressed for it.
- o_count:
  - Increments on an input transfer and decrements on an output transfer; stays unchanged when both occur in the same cycle.
  - Never exceeds NUM_PIPELINE_STAGES.

## Timing
- Latency: with no stall, the result for an operand pair accepted at edge t is presented (o_valid = 1) after edge t+NUM_PIPELINE_STAGES-1, i.e. NUM_PIPELINE_STAGES cycles after acceptance.
- Throughput: one operation per cycle while o_ready = 1.
- Stalled output: Q_out, R_out, o_dbz and o_valid stay stable while o_valid & ~o_ready.
- Accept and deliver in one cycle: when o_ready = 1 and the pipeline is full, an input is accepted in the same cycle as the output transfer. No bubble is inserted.
- Reset (rst = 0 at an edge):
  - All slot valid bits become 0.
  - o_valid = 0, Q_out = 0, R_out = 0, o_dbz = 0, o_count = 0.
  - i_ready = 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight operation; no partial result is ever emitted.
- Unregistered boundaries add no cycles.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - Adds the i_signed port.
  - When i_signed = 1:
    - The divide runs on |A| and |B|, computed at the input stage.
    - Q is negated when sign(A) != sign(B).
    - R is negated when A < 0 (truncating division; R takes the sign of A).
    - The fixup happens in the output stage.
  - MIN / -1 gives Q = MIN, R = 0, o_dbz = 0.
  - i_signed = 0 behaves exactly like the unsigned build.
- DIVIDER_SIGNED_EN undefined: no i_signed port, no sign logic, unsigned only.

## Test plan
All scenarios use DATAWIDTH=8 and NUM_PIPELINE_STAGES=3.
- Basic: A=200, B=7, o_ready=1 -> o_valid rises 3 cycles after acceptance; Q=28, R=4, o_dbz=0.
- Streaming and stall: 10 back-to-back random pairs, o_ready held 0 for 4 cycles mid-stream:
  - Every result matches the model, in order, with none lost or duplicated.
  - i_ready = 0 exactly while o_valid & ~o_ready.
  - o_count peaks at 3.
- Divide by zero: A=0x5A, B=0 -> Q=0xFF, R=0x5A, o_dbz=1.
- Signed (macro on, i_signed=1):
  - A=-7, B=2 -> Q=-3 (0xFD), R=-1 (0xFF).
  - A=-128, B=-1 -> Q=0x80, R=0.
- Reset mid-flight: accept 2 operations, then pull rst low for 1 cycle -> o_valid never rises for them, o_count=0, and the next operation has latency 3.
- Simultaneous accept/deliver: pipeline full with o_ready=1 and i_valid=1 -> o_count stays 3 and one result is delivered every cycle.

Source files
------------

// File: rtl/array_divider_rv_if.sv
// Ready/valid operand and result bundle for array_divider_rv.
// The i_signed wire exists only when DIVIDER_SIGNED_EN is defined.
interface array_divider_rv_if #(
    parameter int DATAWIDTH = 16
);
    localparam int CW = $clog2(DATAWIDTH + 2);

    logic                 i_valid;
    logic                 i_ready;
    logic [DATAWIDTH-1:0] A;
    logic [DATAWIDTH-1:0] B;
`ifdef DIVIDER_SIGNED_EN
    logic                 i_signed;
`endif
    logic                 o_valid;
    logic                 o_ready;
    logic [DATAWIDTH-1:0] Q_out;
    logic [DATAWIDTH-1:0] R_out;
    logic                 o_dbz;
    logic [CW-1:0]        o_count;

    modport master (
`ifdef DIVIDER_SIGNED_EN
        output i_signed,
`endif
        output i_valid, A, B, o_ready,
        input  i_ready, o_valid, Q_out, R_out, o_dbz, o_count
    );

    modport slave (
`ifdef DIVIDER_SIGNED_EN
        input  i_signed,
`endif
        input  i_valid, A, B, o_ready,
        output i_ready, o_valid, Q_out, R_out, o_dbz, o_count
    );
endinterface

// File: rtl/array_divider_rv.sv
// Pipelined restoring array divider with ready/valid handshake and global stall.
// Define DIVIDER_SIGNED_EN to add the i_signed port and two's complement mode.
module array_divider_rv #(
    parameter int DATAWIDTH           = 16,
    parameter int NUM_PIPELINE_STAGES = 4,
    parameter int INSTANCE_ID         = 0
) (
    input logic              clk,
    input logic              rst,
    array_divider_rv_if.slave bus
);
    localparam int DW = DATAWIDTH;
    localparam int NS = NUM_PIPELINE_STAGES;
    localparam int CW = $clog2(DW + 2);

    if (DW < 4 || DW > 64 || NS < 1 || NS > DW + 1 || INSTANCE_ID < 0) begin : cfg_check
        $error("array_divider_rv: illegal parameter set");
    end

    function automatic logic [DW-1:0] negate_if(input logic en, input logic [DW-1:0] x);
        return en ? -x : x;
    endfunction

    logic stall;
    logic in_xfer;
    logic out_xfer;

    assign stall       = bus.o_valid & ~bus.o_ready;
    assign bus.i_ready = ~stall;
    assign in_xfer     = bus.i_valid & ~stall;
    assign out_xfer    = bus.o_valid & bus.o_ready;

    logic          dbz_s;
    logic          nq_s;
    logic          nr_s;
    logic [DW-1:0] a_s;
    logic [DW-1:0] b_s;

    assign dbz_s = (bus.B == '0);

`ifdef DIVIDER_SIGNED_EN
    function automatic logic [DW-1:0] abs_val(input logic en, input logic [DW-1:0] x);
        return (en && x[DW-1]) ? -x : x;
    endfunction

    // Divide by zero keeps the raw dividend so R_out reproduces A unchanged.
    logic sgn_s;
    assign sgn_s = bus.i_signed & ~dbz_s;
    assign a_s   = abs_val(sgn_s, bus.A);
    assign b_s   = abs_val(sgn_s, bus.B);
    assign nq_s  = sgn_s & (bus.A[DW-1] ^ bus.B[DW-1]);
    assign nr_s  = sgn_s & bus.A[DW-1];
`else
    assign a_s  = bus.A;
    assign b_s  = bus.B;
    assign nq_s = 1'b0;
    assign nr_s = 1'b0;
`endif

    // acc holds {partial remainder, unconsumed dividend bits, quotient bits}.
    for (genvar k = 0; k < DW; k++) begin : row
        logic            v_in, dbz_in, nq_in, nr_in;
        logic [2*DW-1:0] acc_in;
        logic [DW-1:0]   b_in;
        logic            v, dbz, nq, nr;
        logic [2*DW-1:0] acc;
        logic [DW-1:0]   b;
        logic [DW:0]     shifted;
        logic            ge;
        logic [DW-1:0]   rem_nx;
        logic [2*DW-1:0] acc_nx;

        if (k == 0) begin : src
            assign v_in   = in_xfer;
            assign acc_in = {{DW{1'b0}}, a_s};
            assign b_in   = b_s;
            assign dbz_in = dbz_s;
            assign nq_in  = nq_s;
            assign nr_in  = nr_s;
        end else begin : src
            assign v_in   = row[k-1].v;
            assign acc_in = row[k-1].acc_nx;
            assign b_in   = row[k-1].b;
            assign dbz_in = row[k-1].dbz;
            assign nq_in  = row[k-1].nq;
            assign nr_in  = row[k-1].nr;
        end

        // Boundary k register (only the first NS-1 boundaries are registered).
        if (k <= NS - 2) begin : bnd_reg
            always_ff @(posedge clk) begin
                if (!rst)
                    v <= 1'b0;
                else if (!stall)
                    v <= v_in;
            end
            always_ff @(posedge clk) begin
                if (!stall) begin
                    acc <= acc_in;
                    b   <= b_in;
                    dbz <= dbz_in;
                    nq  <= nq_in;
                    nr  <= nr_in;
                end
            end
        end else begin : bnd_comb
            assign v   = v_in;
            assign acc = acc_in;
            assign b   = b_in;
            assign dbz = dbz_in;
            assign nq  = nq_in;
            assign nr  = nr_in;
        end

        assign shifted = acc[2*DW-1:DW-1];
        assign ge      = (shifted >= {1'b0, b});
        assign rem_nx  = ge ? (shifted[DW-1:0] - b) : shifted[DW-1:0];
        assign acc_nx  = {rem_nx, acc[DW-2:0], ge};
    end

    // Boundary DW: output register with sign fixup applied on the way in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.o_valid <= 1'b0;
            bus.Q_out   <= '0;
            bus.R_out   <= '0;
            bus.o_dbz   <= 1'b0;
        end else if (!stall) begin
            bus.o_valid <= row[DW-1].v;
            bus.Q_out   <= negate_if(row[DW-1].nq, row[DW-1].acc_nx[DW-1:0]);
            bus.R_out   <= negate_if(row[DW-1].nr, row[DW-1].acc_nx[2*DW-1:DW]);
            bus.o_dbz   <= row[DW-1].dbz;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            bus.o_count <= '0;
        else if (in_xfer && !out_xfer)
            bus.o_count <= bus.o_count + CW'(1);
        else if (out_xfer && !in_xfer)
            bus.o_count <= bus.o_count - CW'(1);
    end
endmodule

// File: tb/tb_array_divider_rv.sv
// Directed bench for array_divider_rv at DATAWIDTH=8, NUM_PIPELINE_STAGES=3.
// Signed vectors are exercised only when DIVIDER_SIGNED_EN is defined.
module tb_array_divider_rv;
    localparam int DW = 8;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    array_divider_rv_if #(.DATAWIDTH(DW)) bus ();

    array_divider_rv #(
        .DATAWIDTH(DW),
        .NUM_PIPELINE_STAGES(NS),
        .INSTANCE_ID(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Drives one operation and waits for its result; lat = -1 on timeout.
    task automatic send_wait(input logic [7:0] a, input logic [7:0] b, input logic sgn, output int lat);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
`ifdef DIVIDER_SIGNED_EN
        bus.i_signed = sgn;
`else
        if (sgn) bus.A = a;
`endif
        bus.i_valid = 1'b1;
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.o_valid) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0b expected 0", bus.o_valid); end
        checks++;
        if (bus.Q_out !== 8'h00 || bus.R_out !== 8'h00) begin
            errors++; $display("FAIL reset_q_r: got Q=%0h R=%0h expected 0 0", bus.Q_out, bus.R_out);
        end
        checks++;
        if (bus.o_dbz !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++; $display("FAIL reset_dbz_count: got dbz=%0b count=%0d expected 0 0", bus.o_dbz, bus.o_count);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %0b expected 1", bus.i_ready); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        bus.A = 8'd200; bus.B = 8'd7; bus.i_valid = 1'b1; bus.o_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_count !== 4'd1 || bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL basic_cycle1: got count=%0d valid=%0b expected 1 0", bus.o_count, bus.o_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_cycle2: got valid=%0b expected 0", bus.o_valid); end
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.Q_out !== 8'd28 || bus.R_out !== 8'd4 || bus.o_dbz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got v=%0b Q=%0d R=%0d dbz=%0b expected 1 28 4 0",
                     bus.o_valid, bus.Q_out, bus.R_out, bus.o_dbz);
        end
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++; $display("FAIL basic_drain: got valid=%0b count=%0d expected 0 0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_dbz();
        int lat;
        send_wait(8'h5A, 8'h00, 1'b0, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL dbz_latency: got %0d expected 3", lat); end
        checks++;
        if (bus.Q_out !== 8'hFF || bus.R_out !== 8'h5A || bus.o_dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got Q=%0h R=%0h dbz=%0b expected ff 5a 1", bus.Q_out, bus.R_out, bus.o_dbz);
        end
        @(negedge clk);
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [7:0] va [5] = '{8'hF9, 8'h80, 8'h07, 8'hFA, 8'hF9};
        logic [7:0] vb [5] = '{8'h02, 8'hFF, 8'hFE, 8'h00, 8'h02};
        logic       vs [5] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [7:0] eq [5] = '{8'hFD, 8'h80, 8'hFD, 8'hFF, 8'h7C};
        logic [7:0] er [5] = '{8'hFF, 8'h00, 8'h01, 8'hFA, 8'h01};
        logic       ez [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            send_wait(va[i], vb[i], vs[i], lat);
            checks++;
            if (lat != 3 || bus.Q_out !== eq[i] || bus.R_out !== er[i] || bus.o_dbz !== ez[i]) begin
                errors++;
                $display("FAIL signed_%0d: got lat=%0d Q=%0h R=%0h dbz=%0b expected 3 %0h %0h %0b",
                         i, lat, bus.Q_out, bus.R_out, bus.o_dbz, eq[i], er[i], ez[i]);
            end
            @(negedge clk);
        end
        bus.i_signed = 1'b0;
    endtask
`endif

    task automatic test_stream();
        logic [7:0] ta [10] = '{8'd200, 8'd255, 8'd100, 8'd99, 8'd17, 8'd255, 8'd128, 8'd0, 8'd250, 8'd77};
        logic [7:0] tb [10] = '{8'd7,   8'd1,   8'd10,  8'd100, 8'd5, 8'd255, 8'd3,   8'd9, 8'd16,  8'd0};
        logic [7:0] tq [10] = '{8'd28,  8'd255, 8'd10,  8'd0,  8'd3,  8'd1,   8'd42,  8'd0, 8'd15,  8'hFF};
        logic [7:0] tr [10] = '{8'd4,   8'd0,   8'd0,   8'd99, 8'd2,  8'd0,   8'd2,   8'd0, 8'd10,  8'd77};
        logic       tz [10] = '{1'b0,   1'b0,   1'b0,   1'b0,  1'b0,  1'b0,   1'b0,   1'b0, 1'b0,   1'b1};
        int in_idx = 0;
        int out_idx = 0;
        int peak = 0;
        int c = 0;
        while (out_idx < 10 && c < 60) begin
            @(negedge clk);
            bus.o_ready = (c < 5 || c > 8);
            bus.i_valid = (in_idx < 10);
            bus.A = (in_idx < 10) ? ta[in_idx] : 8'd0;
            bus.B = (in_idx < 10) ? tb[in_idx] : 8'd0;
            #1;
            checks++;
            if (bus.i_ready !== ~(bus.o_valid & ~bus.o_ready)) begin
                errors++;
                $display("FAIL stream_i_ready_c%0d: got %0b expected %0b", c, bus.i_ready, ~(bus.o_valid & ~bus.o_ready));
            end
            if (int'(bus.o_count) > peak) peak = int'(bus.o_count);
            if (bus.o_valid && bus.o_ready) begin
                checks++;
                if (bus.Q_out !== tq[out_idx] || bus.R_out !== tr[out_idx] || bus.o_dbz !== tz[out_idx]) begin
                    errors++;
                    $display("FAIL stream_result_%0d: got Q=%0d R=%0d dbz=%0b expected %0d %0d %0b",
                             out_idx, bus.Q_out, bus.R_out, bus.o_dbz, tq[out_idx], tr[out_idx], tz[out_idx]);
                end
                out_idx++;
            end
            if (bus.i_valid && bus.i_ready) in_idx++;
            c++;
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        checks++;
        if (out_idx != 10) begin errors++; $display("FAIL stream_count: got %0d results expected 10", out_idx); end
        checks++;
        if (peak != 3) begin errors++; $display("FAIL stream_peak: got %0d expected 3", peak); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++; $display("FAIL stream_extra: got valid=%0b count=%0d expected 0 0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        int seen = 0;
        @(negedge clk);
        bus.A = 8'd100; bus.B = 8'd3; bus.i_valid = 1'b1; bus.o_ready = 1'b1;
        @(negedge clk);
        bus.A = 8'd90;  bus.B = 8'd4;
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.Q_out !== 8'd0 || bus.R_out !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state: got valid=%0b count=%0d Q=%0h R=%0h expected 0 0 0 0",
                     bus.o_valid, bus.o_count, bus.Q_out, bus.R_out);
        end
        repeat (5) begin
            @(negedge clk);
            if (bus.o_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_ghost: got %0d valid cycles expected 0", seen); end
        send_wait(8'd50, 8'd6, 1'b0, lat);
        checks++;
        if (lat != 3 || bus.Q_out !== 8'd8 || bus.R_out !== 8'd2) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d Q=%0d R=%0d expected 3 8 2", lat, bus.Q_out, bus.R_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [8] = '{8'd60, 8'd61, 8'd90, 8'd91, 8'd255, 8'd33, 8'd1, 8'd144};
        logic [7:0] tb [8] = '{8'd7,  8'd7,  8'd9,  8'd9,  8'd16,  8'd4,  8'd2, 8'd12};
        logic [7:0] tq [8] = '{8'd8,  8'd8,  8'd10, 8'd10, 8'd15,  8'd8,  8'd0, 8'd12};
        logic [7:0] tr [8] = '{8'd4,  8'd5,  8'd0,  8'd1,  8'd15,  8'd1,  8'd1, 8'd0};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 10) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.Q_out !== tq[c-3] || bus.R_out !== tr[c-3]) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got v=%0b Q=%0d R=%0d expected 1 %0d %0d",
                             c - 3, bus.o_valid, bus.Q_out, bus.R_out, tq[c-3], tr[c-3]);
                end
            end
            if (c >= 3 && c <= 8) begin
                checks++;
                if (bus.o_count !== 4'd3) begin
                    errors++; $display("FAIL b2b_count_c%0d: got %0d expected 3", c, bus.o_count);
                end
            end
            bus.o_ready = 1'b1;
            bus.i_valid = (c < 8);
            bus.A = (c < 8) ? ta[c] : 8'd0;
            bus.B = (c < 8) ? tb[c] : 8'd0;
        end
        bus.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++; $display("FAIL b2b_drain: got valid=%0b count=%0d expected 0 0", bus.o_valid, bus.o_count);
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        bus.A       = '0;
        bus.B       = '0;
`ifdef DIVIDER_SIGNED_EN
        bus.i_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_dbz();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_stream();
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
